// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : byte-stream program loader feeding the instruction memory
//               write port. Optional checksum stage: IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte_data,
  output logic                  o_byte_ready,
  output logic                  o_we_inst,
  output logic [ADDR_WIDTH-1:0] o_addr_inst,
  output logic [DATA_WIDTH-1:0] o_wrdata_inst,
  output logic                  o_core_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd6;
  localparam logic [2:0] S_FINAL = S_CHK;
`else
  localparam logic [2:0] S_FINAL = S_DONE;
`endif

  localparam logic [32:0] c_depth = 33'd1 << ADDR_WIDTH;

  logic [2:0]            state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           len_q, len_d;
  logic [23:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remain_q, remain_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  logic        w_xfer;
  logic [31:0] w_len;

  assign w_xfer = i_byte_valid & o_byte_ready;
  assign w_len  = {i_byte_data, len_q};

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      len_q      <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      remain_q   <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      len_q      <= len_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Next state and datapath updates
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    len_d      = len_q;
    word_d     = word_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) begin
          state_d    = S_LEN;
          byte_idx_d = '0;
          addr_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      S_LEN: begin
        if (w_xfer) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: len_d[7:0]   = i_byte_data;
            2'd1: len_d[15:8]  = i_byte_data;
            2'd2: len_d[23:16] = i_byte_data;
            default: begin
              remain_d = w_len[ADDR_WIDTH:0];
              if (w_len == 32'd0)               state_d = S_FINAL;
              else if ({1'b0, w_len} > c_depth) state_d = S_ERR;
              else                              state_d = S_DATA;
            end
          endcase
        end
      end
      S_DATA: begin
        if (w_xfer) begin
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = sum_q + i_byte_data;
`endif
          case (byte_idx_q)
            2'd0: word_d[7:0]   = i_byte_data;
            2'd1: word_d[15:8]  = i_byte_data;
            2'd2: word_d[23:16] = i_byte_data;
            default: begin
              // Capture the write address/data here so they hold after WRITE
              wr_addr_d = addr_q;
              wr_data_d = DATA_WIDTH'({i_byte_data, word_q});
              state_d   = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        addr_d   = addr_q + 1'b1;
        remain_d = remain_q - 1'b1;
        state_d  = (remain_q == 1) ? S_FINAL : S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_xfer) state_d = (i_byte_data == sum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    o_byte_ready  = 1'b0;
    o_we_inst     = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    o_err         = 1'b0;
    o_core_rst    = 1'b1;
    o_addr_inst   = wr_addr_q;
    o_wrdata_inst = wr_data_q;
    case (state_q)
      S_LEN, S_DATA: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
      end
      S_WRITE: begin
        o_we_inst = 1'b1;
        o_busy    = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
      end
`endif
      S_DONE: begin
        o_done     = 1'b1;
        o_core_rst = 1'b0;
      end
      S_ERR:   o_err = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire
